// File: rtl/fp_cmp_result_stage.sv
// rtl/fp_cmp_result_stage.sv - registered result stage behind the FP compare unit
//
// Forms the instruction result from the compare vector and operands:
// set-on-compare, the raw compare vector, and FMIN/FMAX. Both sides use
// valid/ready. A 2-entry buffer (output register plus skid register) lets
// the stage keep accepting while the output is stalled. Each result carries
// an invalid-operation flag, and a sticky copy feeds the FP status register.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid, i_ready  upstream handshake (i_ready registered)
//   op                0 FCMP, 1 FSEQ, 2 FSLT, 3 FSLE, 4 FSUN, 5 FMIN, 6 FMAX, 7 = FCMP
//   a, b              operands that were compared
//   cmp               {unord, lt_mag, le, lt, eq}
//   snan_a, snan_b    operand is a signalling NaN
//   o_valid, o_ready  downstream handshake
//   o, nanx           result and its invalid-operation flag
//   clr_sticky        clear invalid_sticky
//   invalid_sticky    set by any transferred result with nanx=1
module fp_cmp_result_stage #(
  parameter int FPWID = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [2:0]       op,
  input  logic [FPWID-1:0] a,
  input  logic [FPWID-1:0] b,
  input  logic [4:0]       cmp,
  input  logic             snan_a,
  input  logic             snan_b,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [FPWID-1:0] o,
  output logic             nanx,
  input  logic             clr_sticky,
  output logic             invalid_sticky
);

  localparam int EXPW = (FPWID == 64) ? 11 : 8;
  localparam int MANW = FPWID - 1 - EXPW;
  localparam logic [FPWID-1:0] CANON_QNAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};

  localparam logic [2:0] OP_FCMP = 3'd0;
  localparam logic [2:0] OP_FSEQ = 3'd1;
  localparam logic [2:0] OP_FSLT = 3'd2;
  localparam logic [2:0] OP_FSLE = 3'd3;
  localparam logic [2:0] OP_FSUN = 3'd4;
  localparam logic [2:0] OP_FMIN = 3'd5;
  localparam logic [2:0] OP_FMAX = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [FPWID-1:0] skid_q;
  logic             skid_nanx;

  logic             accept;
  logic             transfer;
  logic             a_nan;
  logic             b_nan;
  logic [FPWID-1:0] res_d;
  logic             nanx_d;

  assign accept   = i_valid & i_ready;
  assign transfer = o_valid & o_ready;

  // NaN detection from the operand bits; cmp[4] alone cannot tell which side is NaN.
  assign a_nan = (&a[FPWID-2 -: EXPW]) & (|a[MANW-1:0]);
  assign b_nan = (&b[FPWID-2 -: EXPW]) & (|b[MANW-1:0]);

  always_comb begin
    res_d  = '0;
    nanx_d = snan_a | snan_b;
    case (op)
      OP_FSEQ: res_d[0] = cmp[0];
      OP_FSLT: begin
        res_d[0] = cmp[1];
        nanx_d   = cmp[4];   // signalling compare: any NaN is invalid
      end
      OP_FSLE: begin
        res_d[0] = cmp[2];
        nanx_d   = cmp[4];
      end
      OP_FSUN: res_d[0] = cmp[4];
      OP_FMIN, OP_FMAX: begin
        if (a_nan && b_nan) begin
          res_d = CANON_QNAN;
        end else if (a_nan) begin
          res_d = b;
        end else if (b_nan) begin
          res_d = a;
        end else if (cmp[0]) begin
          // Equal values (incl. +0/-0): FMIN prefers the negative sign, FMAX the positive.
          if (op == OP_FMIN) res_d = a[FPWID-1] ? a : b;
          else               res_d = a[FPWID-1] ? b : a;
        end else begin
          if (op == OP_FMIN) res_d = cmp[1] ? a : b;
          else               res_d = cmp[1] ? b : a;
        end
      end
      default: res_d[4:0] = cmp;   // FCMP and the reserved code
    endcase
  end

  // Occupancy FSM. The output register always holds the oldest entry; the
  // skid register only fills while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      o_valid   <= 1'b0;
      i_ready   <= 1'b1;
      o         <= '0;
      nanx      <= 1'b0;
      skid_q    <= '0;
      skid_nanx <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            o       <= res_d;
            nanx    <= nanx_d;
            o_valid <= 1'b1;
            state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !transfer) begin
            skid_q    <= res_d;
            skid_nanx <= nanx_d;
            i_ready   <= 1'b0;
            state     <= ST_TWO;
          end else if (transfer && !accept) begin
            o_valid <= 1'b0;
            state   <= ST_EMPTY;
          end else if (accept && transfer) begin
            o    <= res_d;
            nanx <= nanx_d;
          end
        end
        ST_TWO: begin
          if (transfer) begin
            o       <= skid_q;
            nanx    <= skid_nanx;
            i_ready <= 1'b1;
            state   <= ST_ONE;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          o_valid <= 1'b0;
          i_ready <= 1'b1;
        end
      endcase
    end
  end

  // Set wins over a same-cycle clear so no exception is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalid_sticky <= 1'b0;
    end else if (transfer && nanx) begin
      invalid_sticky <= 1'b1;
    end else if (clr_sticky) begin
      invalid_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_cmp_result_stage.sv
// tb/tb_fp_cmp_result_stage.sv - self-checking bench for fp_cmp_result_stage
module tb_fp_cmp_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  cmp;
  logic        snan_a, snan_b;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o;
  logic        nanx;
  logic        clr_sticky;
  logic        invalid_sticky;

  fp_cmp_result_stage #(.FPWID(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready),
    .op(op), .a(a), .b(b), .cmp(cmp),
    .snan_a(snan_a), .snan_b(snan_b),
    .o_valid(o_valid), .o_ready(o_ready),
    .o(o), .nanx(nanx),
    .clr_sticky(clr_sticky), .invalid_sticky(invalid_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        nx;
  } exp_t;

  exp_t q[$];
  logic sticky_m;
  logic last_acc;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // Signed ordering key: IEEE magnitudes order like integers; -0 and +0 share key 0.
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [4:0] ref_cmp(input logic [31:0] x, input logic [31:0] y);
    longint kx, ky;
    logic eq, lt, le, ltm;
    if (is_nan(x) || is_nan(y)) return 5'b10000;
    kx  = fkey(x);
    ky  = fkey(y);
    eq  = (kx == ky);
    lt  = (kx < ky);
    le  = lt | eq;
    ltm = (x[30:0] < y[30:0]);
    return {1'b0, ltm, le, lt, eq};
  endfunction

  function automatic exp_t ref_model(input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y,
                                     input logic [4:0] c, input logic sx, input logic sy);
    exp_t e;
    logic [31:0] lo, hi;
    e.res = 32'd0;
    e.nx  = sx | sy;
    case (opc)
      3'd1: e.res = {31'd0, c[0]};
      3'd2: begin e.res = {31'd0, c[1]}; e.nx = c[4]; end
      3'd3: begin e.res = {31'd0, c[2]}; e.nx = c[4]; end
      3'd4: e.res = {31'd0, c[4]};
      3'd5, 3'd6: begin
        if (is_nan(x) && is_nan(y)) begin
          lo = 32'h7FC00000; hi = 32'h7FC00000;
        end else if (is_nan(x)) begin
          lo = y; hi = y;
        end else if (is_nan(y)) begin
          lo = x; hi = x;
        end else if (fkey(x) < fkey(y)) begin
          lo = x; hi = y;
        end else if (fkey(y) < fkey(x)) begin
          lo = y; hi = x;
        end else begin
          lo = x[31] ? x : y;
          hi = x[31] ? y : x;
        end
        e.res = (opc == 3'd5) ? lo : hi;
      end
      default: e.res = {27'd0, c};
    endcase
    return e;
  endfunction

  // One clock: drive inputs after the falling edge, check against the model,
  // update the model with this cycle's handshakes, then let the edge happen.
  task automatic step(input logic v, input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] c, input logic sx, input logic sy, input logic r, input logic clr);
    logic acc, xfer;
    exp_t e;
    i_valid = v; op = opc; a = x; b = y; cmp = c;
    snan_a = sx; snan_b = sy; o_ready = r; clr_sticky = clr;
    #1;
    check("i_ready", i_ready, q.size() < 2);
    check("o_valid", o_valid, q.size() > 0);
    check("invalid_sticky", invalid_sticky, sticky_m);
    if (q.size() > 0) begin
      check("o", o, q[0].res);
      check("nanx", nanx, q[0].nx);
    end
    acc  = v && (q.size() < 2);
    xfer = r && (q.size() > 0);
    if (xfer) begin
      if (q[0].nx) sticky_m = 1'b1;
      else if (clr) sticky_m = 1'b0;
      void'(q.pop_front());
    end else if (clr) begin
      sticky_m = 1'b0;
    end
    if (acc) begin
      e = ref_model(opc, x, y, c, sx, sy);
      q.push_back(e);
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, r, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] pool [10];
    int k;
    pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h40000000,
             32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001, 32'hFFA00000};
    k = $urandom_range(0, 12);
    if (k < 10) return pool[k];
    return {$urandom_range(0, 1), 8'($urandom_range(0, 254)), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] x, y;
    int tries;
    rst_n = 1'b0; i_valid = 0; op = 0; a = 0; b = 0; cmp = 0;
    snan_a = 0; snan_b = 0; o_ready = 0; clr_sticky = 0;
    sticky_m = 1'b0; last_acc = 1'b0;
    #12;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_i_ready", i_ready, 1'b1);
    check("rst_o", o, 32'd0);
    check("rst_nanx", nanx, 1'b0);
    check("rst_sticky", invalid_sticky, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: FSLT 1.0 < 2.0
    step(1, 3'd2, 32'h3F800000, 32'h40000000, 5'b00110, 0, 0, 1, 0);
    check("t1_o", o, 32'd1);
    check("t1_nanx", nanx, 1'b0);
    idle(1);
    check("t1_one_cycle", o_valid, 1'b0);

    // 2: FMIN/FMAX of +0 and -0
    step(1, 3'd5, 32'h00000000, 32'h80000000, 5'b00101, 0, 0, 1, 0);
    check("t2_fmin", o, 32'h80000000);
    step(1, 3'd6, 32'h00000000, 32'h80000000, 5'b00101, 0, 0, 1, 0);
    check("t2_fmax", o, 32'h00000000);

    // 3: quiet NaN vs 3.0
    step(1, 3'd6, 32'h7FC00000, 32'h40400000, 5'b10000, 0, 0, 1, 0);
    check("t3_fmax", o, 32'h40400000);
    check("t3_fmax_nanx", nanx, 1'b0);
    step(1, 3'd3, 32'h7FC00000, 32'h40400000, 5'b10000, 0, 0, 1, 0);
    check("t3_fsle", o, 32'd0);
    check("t3_fsle_nanx", nanx, 1'b1);
    idle(1);
    check("t3_sticky", invalid_sticky, 1'b1);

    // 4: both NaN -> canonical qNaN, then clear sticky
    step(1, 3'd5, 32'h7F800001, 32'h7FC00000, 5'b10000, 1, 0, 1, 0);
    check("t4_fmin", o, 32'h7FC00000);
    check("t4_nanx", nanx, 1'b1);
    idle(1);
    step(0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 0, 1, 1);
    check("t4_clr", invalid_sticky, 1'b0);

    // 5: stall with three back-to-back requests
    step(1, 3'd1, 32'h3F800000, 32'h3F800000, 5'b00101, 0, 0, 0, 0);
    step(1, 3'd4, 32'h7FC00000, 32'h3F800000, 5'b10000, 0, 0, 0, 0);
    check("t5_full", i_ready, 1'b0);
    step(1, 3'd0, 32'h3F800000, 32'h40000000, 5'b01110, 0, 0, 0, 0);
    check("t5_third_refused", last_acc, 1'b0);
    tries = 0;
    do begin
      step(1, 3'd0, 32'h3F800000, 32'h40000000, 5'b01110, 0, 0, 1, 0);
      tries++;
    end while (!last_acc && tries < 6);
    check("t5_third_accepted", last_acc, 1'b1);
    tries = 0;
    while (q.size() > 0 && tries < 10) begin idle(1); tries++; end
    check("t5_drained", q.size(), 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      x = pick_operand();
      y = pick_operand();
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), x, y, ref_cmp(x, y),
           is_nan(x) && !x[22], is_nan(y) && !y[22],
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
    end

    // 6: asynchronous reset while both entries are occupied
    step(1, 3'd5, 32'h7F800001, 32'h3F800000, 5'b10000, 1, 0, 1, 0);
    step(1, 3'd1, 32'h3F800000, 32'h3F800000, 5'b00101, 0, 0, 1, 0);
    step(1, 3'd2, 32'h3F800000, 32'h40000000, 5'b00110, 0, 0, 0, 0);
    step(1, 3'd2, 32'h3F800000, 32'h40000000, 5'b00110, 0, 0, 0, 0);
    check("t6_full", i_ready, 1'b0);
    check("t6_sticky_set", invalid_sticky, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_o_valid", o_valid, 1'b0);
    check("t6_i_ready", i_ready, 1'b1);
    check("t6_sticky", invalid_sticky, 1'b0);
    q.delete();
    sticky_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    o_ready = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    idle(1);
    idle(1);
    check("t6_no_stale", o_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
